// File: rtl/sig_period_gen.sv
// Programmable square-wave source: exact period/high time in clk_i cycles, optional burst length,
// graceful stop, and config updates that take effect only at period boundaries.
module sig_period_gen #(
  parameter int T_CNT_WIDTH = 32,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic                   cfg_we_i,
  input  logic [T_CNT_WIDTH-1:0] cfg_period_i,
  input  logic [T_CNT_WIDTH-1:0] cfg_high_i,
  input  logic [BURST_WIDTH-1:0] cfg_burst_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  output logic                   sig_o,
  output logic                   period_stb_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                 state_q, state_d;
  logic [T_CNT_WIDTH-1:0] t_cnt_q, t_cnt_d;
  logic [BURST_WIDTH-1:0] n_per_q, n_per_d;
  logic [T_CNT_WIDTH-1:0] act_period_q, act_period_d, act_high_q, act_high_d;
  logic [BURST_WIDTH-1:0] act_burst_q, act_burst_d;
  logic [T_CNT_WIDTH-1:0] pend_period_q, pend_period_d, pend_high_q, pend_high_d;
  logic [BURST_WIDTH-1:0] pend_burst_q, pend_burst_d;
  logic                   dirty_q, dirty_d;
  logic                   stop_pend_q, stop_pend_d;
  logic                   sig_q, sig_d;
  logic                   stb_q, stb_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   pend_valid;
  logic                   last_cnt;
  logic                   burst_end;
  logic                   stop_now;
  logic [T_CNT_WIDTH-1:0] t_cnt_inc;
  logic [BURST_WIDTH:0]   n_per_inc;

  always_comb begin
    pend_valid = (pend_period_q >= T_CNT_WIDTH'(2)) && (pend_high_q != '0)
                 && (pend_high_q < pend_period_q);
    t_cnt_inc  = t_cnt_q + T_CNT_WIDTH'(1);
    last_cnt   = (t_cnt_q == act_period_q - T_CNT_WIDTH'(1));
    n_per_inc  = {1'b0, n_per_q} + (BURST_WIDTH+1)'(1);
    burst_end  = (act_burst_q != '0) && (n_per_inc == {1'b0, act_burst_q});
    stop_now   = stop_pend_q | stop_i;
  end

  always_comb begin
    state_d      = state_q;
    t_cnt_d      = t_cnt_q;
    n_per_d      = n_per_q;
    act_period_d = act_period_q;
    act_high_d   = act_high_q;
    act_burst_d  = act_burst_q;
    pend_period_d = pend_period_q;
    pend_high_d  = pend_high_q;
    pend_burst_d = pend_burst_q;
    dirty_d      = dirty_q;
    stop_pend_d  = stop_pend_q;
    sig_d        = 1'b0;
    stb_d        = 1'b0;
    done_d       = 1'b0;
    err_d        = err_q;

    unique case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start_i && !stop_i) begin
          if (pend_valid) begin
            act_period_d = pend_period_q;
            act_high_d   = pend_high_q;
            act_burst_d  = pend_burst_q;
            err_d        = 1'b0;
            t_cnt_d      = '0;
            n_per_d      = '0;
            dirty_d      = 1'b0;
            sig_d        = 1'b1;
            stb_d        = 1'b1;
            state_d      = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!last_cnt) begin
          t_cnt_d     = t_cnt_inc;
          sig_d       = (t_cnt_inc < act_high_q);
          stop_pend_d = stop_now;
        end else if (burst_end || stop_now) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end else begin
          t_cnt_d = '0;
          // Saturate so a long continuous run never wraps the period count.
          n_per_d = (&n_per_q) ? n_per_q : n_per_inc[BURST_WIDTH-1:0];
          sig_d   = 1'b1;
          stb_d   = 1'b1;
          dirty_d = 1'b0;
          if (dirty_q) begin
            if (pend_valid) begin
              act_period_d = pend_period_q;
              act_high_d   = pend_high_q;
              act_burst_d  = pend_burst_q;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A write on the boundary edge itself belongs to the following period.
    if (cfg_we_i) begin
      pend_period_d = cfg_period_i;
      pend_high_d   = cfg_high_i;
      pend_burst_d  = cfg_burst_i;
      dirty_d       = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q       <= S_IDLE;
      t_cnt_q       <= '0;
      n_per_q       <= '0;
      act_period_q  <= '0;
      act_high_q    <= '0;
      act_burst_q   <= '0;
      pend_period_q <= '0;
      pend_high_q   <= '0;
      pend_burst_q  <= '0;
      dirty_q       <= 1'b0;
      stop_pend_q   <= 1'b0;
      sig_q         <= 1'b0;
      stb_q         <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      t_cnt_q       <= t_cnt_d;
      n_per_q       <= n_per_d;
      act_period_q  <= act_period_d;
      act_high_q    <= act_high_d;
      act_burst_q   <= act_burst_d;
      pend_period_q <= pend_period_d;
      pend_high_q   <= pend_high_d;
      pend_burst_q  <= pend_burst_d;
      dirty_q       <= dirty_d;
      stop_pend_q   <= stop_pend_d;
      sig_q         <= sig_d;
      stb_q         <= stb_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign sig_o        = sig_q;
  assign period_stb_o = stb_q;
  assign busy_o       = (state_q == S_RUN);
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_sig_period_gen.sv
// Directed bench for sig_period_gen: a position-in-period model checked every cycle,
// plus literal timing expectations measured from the DUT waveform.
module tb_sig_period_gen;
  localparam int TW = 32;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [TW-1:0] cfg_p = '0;
  logic [TW-1:0] cfg_h = '0;
  logic [BW-1:0] cfg_b = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          sig_o, period_stb_o, busy_o, done_o, err_o;

  sig_period_gen #(.T_CNT_WIDTH(TW), .BURST_WIDTH(BW)) dut (
    .clk_i(clk), .arst_ni(arst_n), .cfg_we_i(cfg_we),
    .cfg_period_i(cfg_p), .cfg_high_i(cfg_h), .cfg_burst_i(cfg_b),
    .start_i(start), .stop_i(stop),
    .sig_o(sig_o), .period_stb_o(period_stb_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: "which cycle of the period are we in" and "how many periods have started".
  bit     m_run, m_err, m_done, m_dirty, m_stop;
  longint m_pos, m_started;
  longint m_p, m_h, m_b, m_pp, m_ph, m_pb;

  function automatic bit cfg_ok(input longint p, input longint h);
    return (p >= 2) && (h >= 1) && (h < p);
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_run = 0; m_err = 0; m_done = 0; m_dirty = 0; m_stop = 0;
      m_pos = 0; m_started = 0;
      m_p = 0; m_h = 0; m_b = 0; m_pp = 0; m_ph = 0; m_pb = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        m_stop = 0;
        if (start && !stop) begin
          if (cfg_ok(m_pp, m_ph)) begin
            m_p = m_pp; m_h = m_ph; m_b = m_pb;
            m_err = 0; m_run = 1; m_pos = 0; m_started = 1; m_dirty = 0;
          end else begin
            m_err = 1;
          end
        end
      end else begin
        if (m_pos == m_p - 1) begin
          if ((m_b != 0 && m_started == m_b) || m_stop || stop) begin
            m_run = 0; m_done = 1; m_stop = 0;
          end else begin
            m_pos = 0; m_started++;
            if (m_dirty) begin
              if (cfg_ok(m_pp, m_ph)) begin m_p = m_pp; m_h = m_ph; m_b = m_pb; end
              else m_err = 1;
            end
            m_dirty = 0;
          end
        end else begin
          m_pos++;
          m_stop = m_stop | stop;
        end
      end
      if (cfg_we) begin
        m_pp = cfg_p; m_ph = cfg_h; m_pb = cfg_b; m_dirty = 1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Waveform capture for the literal timing checks.
  int rise_q[$];
  int hlen_q[$];
  int done_q[$];
  bit prev_sig = 0;
  int hcnt = 0;

  always @(negedge clk) begin
    chk("sig_o", sig_o, m_run && (m_pos < m_h));
    chk("period_stb_o", period_stb_o, m_run && (m_pos == 0));
    chk("busy_o", busy_o, m_run);
    chk("done_o", done_o, m_done);
    chk("err_o", err_o, m_err);
    if (sig_o && !prev_sig) rise_q.push_back(cyc);
    if (sig_o) hcnt++;
    else if (prev_sig) begin hlen_q.push_back(hcnt); hcnt = 0; end
    if (done_o) done_q.push_back(cyc);
    prev_sig = sig_o;
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic write_cfg(input int p, input int h, input int b);
    cfg_p = TW'(p); cfg_h = TW'(h); cfg_b = BW'(b); cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_start(output int s);
    start = 1'b1;
    step();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic clear_caps();
    rise_q.delete(); hlen_q.delete(); done_q.delete();
  endtask

  int s;

  initial begin
    step(3);
    chk("rst_sig", sig_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_done", done_o, 0);
    arst_n = 1'b1;
    step(2);

    // 1: continuous 10/3
    write_cfg(10, 3, 0);
    clear_caps();
    do_start(s);
    step(35);
    chk("t1_rises", rise_q.size(), 4);
    if (rise_q.size() >= 3) begin
      chk("t1_rise0", rise_q[0], s);
      chk("t1_rise1", rise_q[1] - rise_q[0], 10);
      chk("t1_rise2", rise_q[2] - rise_q[1], 10);
    end
    if (hlen_q.size() >= 2) begin
      chk("t1_high0", hlen_q[0], 3);
      chk("t1_high1", hlen_q[1], 3);
    end
    do_stop();
    step(12);
    chk("t1_stop_done", done_q.size(), 1);

    // 2: burst of 4
    write_cfg(10, 3, 4);
    clear_caps();
    do_start(s);
    step(45);
    chk("t2_pulses", rise_q.size(), 4);
    chk("t2_dones", done_q.size(), 1);
    if (done_q.size() >= 1) chk("t2_done_cyc", done_q[0] - s, 40);
    chk("t2_busy_end", busy_o, 0);

    // 3: invalid configurations, then recovery
    write_cfg(5, 0, 0);
    do_start(s);
    chk("t3_err_h0", err_o, 1);
    chk("t3_busy_h0", busy_o, 0);
    write_cfg(1, 1, 0);
    do_start(s);
    chk("t3_err_p1", err_o, 1);
    write_cfg(5, 5, 0);
    do_start(s);
    chk("t3_err_heqp", err_o, 1);
    chk("t3_sig", sig_o, 0);
    write_cfg(5, 2, 1);
    do_start(s);
    chk("t3_err_clr", err_o, 0);
    chk("t3_busy_ok", busy_o, 1);
    step(6);

    // 4: reconfigure mid-period
    write_cfg(10, 3, 0);
    clear_caps();
    do_start(s);
    step(2);
    write_cfg(6, 2, 0);
    step(24);
    if (rise_q.size() >= 4) begin
      chk("t4_rise1", rise_q[1] - s, 10);
      chk("t4_rise2", rise_q[2] - s, 16);
      chk("t4_rise3", rise_q[3] - s, 22);
    end else chk("t4_rises", rise_q.size(), 4);
    if (hlen_q.size() >= 3) begin
      chk("t4_high0", hlen_q[0], 3);
      chk("t4_high1", hlen_q[1], 2);
      chk("t4_high2", hlen_q[2], 2);
    end
    do_stop();
    step(8);

    // 5: graceful stop at t_cnt=5, then start+stop together
    write_cfg(10, 3, 0);
    clear_caps();
    do_start(s);
    step(5);
    do_stop();
    step(14);
    chk("t5_rises", rise_q.size(), 1);
    chk("t5_dones", done_q.size(), 1);
    if (done_q.size() >= 1) chk("t5_done_cyc", done_q[0] - s, 10);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    step(2);
    chk("t5_ss_busy", busy_o, 0);
    chk("t5_ss_done", done_q.size(), 1);

    // 6: async reset during the high phase
    do_start(s);
    step(1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("t6_sig_async", sig_o, 0);
    chk("t6_busy_async", busy_o, 0);
    step(1);
    arst_n = 1'b1;
    step(1);
    do_start(s);
    chk("t6_err_after_rst", err_o, 1);
    chk("t6_busy_after_rst", busy_o, 0);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
